timer_regs: RTL and testbench

TIMER_REGS -- requirements
Module: timer_regs

---
 rtl/timer_regs.sv | 119 +++++++++++
 tb/tb_timer_regs.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_regs.sv
// CPU-facing register block for a timer: bus handshake FSM, CTRL/TERM/STATUS/COUNT
// registers, start/halt trigger pulses and a pending/irq interrupt path.
module timer_regs #(
    parameter logic [31:0] TERM_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        ro_trig_start,
    output logic        ro_trig_halt,
    output logic        ro_mode,
    output logic [31:0] ro_termcount,
    input  logic        rf_status,
    input  logic [31:0] rf_currcount,
    input  logic        rf_int,
    output logic        irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 2;

    localparam logic [SEL_W-1:0] SEL_CTRL   = 2'd0;
    localparam logic [SEL_W-1:0] SEL_TERM   = 2'd1;
    localparam logic [SEL_W-1:0] SEL_STATUS = 2'd2;
    localparam logic [SEL_W-1:0] SEL_COUNT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              ien;
    logic              pending;
    logic              ien_nxt;
    logic              pending_nxt;
    logic              access;
    logic              ctrl_wr;
    logic              term_wr;
    logic              status_wr;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] rdata_mux;

    // Byte-lane bits of the address carry no meaning in this map.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus_addr[1:0];

    // Bus handshake: one ACCESS cycle per request, then wait for req to drop.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus_req) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_DONE;
            ST_DONE:   if (!bus_req) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Register decode, next-state values and read mux.
    always_comb begin
        sel         = bus_addr[3:2];
        access      = (state == ST_ACCESS);
        ctrl_wr     = access && bus_we && (sel == SEL_CTRL);
        term_wr     = access && bus_we && (sel == SEL_TERM);
        status_wr   = access && bus_we && (sel == SEL_STATUS);
        ien_nxt     = ctrl_wr ? bus_wdata[1] : ien;
        // A fresh terminal-count event wins over a simultaneous clear.
        pending_nxt = rf_int | (pending & ~(status_wr & bus_wdata[1]));
        rdata_mux   = '0;
        case (sel)
            SEL_CTRL:   rdata_mux = {30'd0, ien, ro_mode};
            SEL_TERM:   rdata_mux = ro_termcount;
            SEL_STATUS: rdata_mux = {30'd0, pending, rf_status};
            SEL_COUNT:  rdata_mux = rf_currcount;
            default:    rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            bus_ack       <= 1'b0;
            bus_rdata     <= '0;
            ro_trig_start <= 1'b0;
            ro_trig_halt  <= 1'b0;
            ro_mode       <= 1'b0;
            ien           <= 1'b0;
            ro_termcount  <= TERM_RESET;
            pending       <= 1'b0;
            irq           <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus_ack       <= access;
            // Halt takes priority when both trigger bits are written together.
            ro_trig_start <= ctrl_wr && bus_wdata[2] && !bus_wdata[3];
            ro_trig_halt  <= ctrl_wr && bus_wdata[3];
            if (access) begin
                bus_rdata <= bus_we ? '0 : rdata_mux;
            end
            if (ctrl_wr) begin
                ro_mode <= bus_wdata[0];
            end
            ien <= ien_nxt;
            if (term_wr) begin
                ro_termcount <= bus_wdata;
            end
            pending <= pending_nxt;
            irq     <= pending_nxt & ien_nxt;
        end
    end

endmodule

// File: tb/tb_timer_regs.sv
// Directed self-checking bench for timer_regs: register access, triggers,
// interrupt pending/W1C behaviour and reset-during-access.
module tb_timer_regs;

    localparam logic [31:0] TERM_RST = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        ro_trig_start;
    logic        ro_trig_halt;
    logic        ro_mode;
    logic [31:0] ro_termcount;
    logic        rf_status;
    logic [31:0] rf_currcount;
    logic        rf_int;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;
    int halt_cnt = 0;

    timer_regs #(.TERM_RESET(TERM_RST)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_ack       (bus_ack),
        .ro_trig_start (ro_trig_start),
        .ro_trig_halt  (ro_trig_halt),
        .ro_mode       (ro_mode),
        .ro_termcount  (ro_termcount),
        .rf_status     (rf_status),
        .rf_currcount  (rf_currcount),
        .rf_int        (rf_int),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    // Count trigger cycles so pulse widths can be checked as deltas.
    always @(negedge clk) begin
        if (ro_trig_start) start_cnt <= start_cnt + 1;
        if (ro_trig_halt)  halt_cnt  <= halt_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus access; returns at the negedge where bus_ack is seen.
    task automatic bus_xfer(input logic we, input logic [3:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        int cyc;
        cyc = 0;
        @(negedge clk);
        bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus_ack && cyc < 8);
        check("ack_latency", 32'(cyc), 32'd2);
        rdata = bus_rdata;
        if (we) check("wr_rdata_zero", bus_rdata, 32'd0);
        bus_req = 1'b0;
    endtask

    logic [31:0] rd;
    int s0, h0, acks;

    initial begin
        reset = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        rf_status = 1'b0; rf_currcount = '0; rf_int = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(bus_ack), 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_trig", {30'd0, ro_trig_start, ro_trig_halt}, 32'd0);
        check("rst_mode", 32'(ro_mode), 32'd0);
        check("rst_term", ro_termcount, TERM_RST);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b1;

        // TERM write then read (addr bits [1:0] ignored)
        bus_xfer(1'b1, 4'h4, 32'h0000_0010, rd);
        check("term_out", ro_termcount, 32'h10);
        bus_xfer(1'b0, 4'h7, 32'h0, rd);
        check("term_rd", rd, 32'h10);

        // CTRL=0x7: mode, ien, one start pulse
        s0 = start_cnt; h0 = halt_cnt;
        bus_xfer(1'b1, 4'h0, 32'h7, rd);
        repeat (3) @(negedge clk);
        check("ctrl7_mode", 32'(ro_mode), 32'd1);
        check("ctrl7_start", 32'(start_cnt - s0), 32'd1);
        check("ctrl7_halt", 32'(halt_cnt - h0), 32'd0);
        bus_xfer(1'b0, 4'h0, 32'h0, rd);
        check("ctrl7_rd", rd, 32'h3);

        // CTRL=0xC: halt only
        s0 = start_cnt; h0 = halt_cnt;
        bus_xfer(1'b1, 4'h0, 32'hC, rd);
        repeat (3) @(negedge clk);
        check("ctrlc_start", 32'(start_cnt - s0), 32'd0);
        check("ctrlc_halt", 32'(halt_cnt - h0), 32'd1);
        check("ctrlc_mode", 32'(ro_mode), 32'd0);
        bus_xfer(1'b0, 4'h0, 32'h0, rd);
        check("ctrlc_rd", rd, 32'h0);

        // Interrupt: enable, pulse rf_int
        bus_xfer(1'b1, 4'h0, 32'h2, rd);
        rf_status = 1'b1;
        @(negedge clk); rf_int = 1'b1;
        @(negedge clk); rf_int = 1'b0;
        check("int_irq", 32'(irq), 32'd1);
        bus_xfer(1'b0, 4'h8, 32'h0, rd);
        check("int_status", rd, 32'h3);

        // Clearing ien drops irq but keeps pending
        bus_xfer(1'b1, 4'h0, 32'h0, rd);
        @(negedge clk);
        check("ien0_irq", 32'(irq), 32'd0);
        bus_xfer(1'b0, 4'h8, 32'h0, rd);
        check("ien0_pending", rd, 32'h3);
        bus_xfer(1'b1, 4'h0, 32'h2, rd);
        @(negedge clk);
        check("ien1_irq", 32'(irq), 32'd1);

        // W1C clears pending
        bus_xfer(1'b1, 4'h8, 32'h2, rd);
        @(negedge clk);
        check("w1c_irq", 32'(irq), 32'd0);
        bus_xfer(1'b0, 4'h8, 32'h0, rd);
        check("w1c_status", rd, 32'h1);

        // W1C coinciding with rf_int: set wins
        fork
            bus_xfer(1'b1, 4'h8, 32'h2, rd);
            begin
                @(negedge clk);
                @(negedge clk); rf_int = 1'b1;
                @(negedge clk); rf_int = 1'b0;
            end
        join
        @(negedge clk);
        check("setwin_irq", 32'(irq), 32'd1);
        bus_xfer(1'b0, 4'h8, 32'h0, rd);
        check("setwin_status", rd, 32'h3);

        // COUNT read sampled in ACCESS, held afterwards; COUNT write ignored
        rf_currcount = 32'h55;
        bus_xfer(1'b0, 4'hC, 32'h0, rd);
        check("count_rd", rd, 32'h55);
        rf_currcount = 32'h66;
        repeat (2) @(negedge clk);
        check("rdata_hold", bus_rdata, 32'h55);
        bus_xfer(1'b1, 4'hC, 32'h99, rd);
        check("count_wr_term", ro_termcount, 32'h10);

        // Long request yields exactly one ack
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 4'h4;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus_ack) acks++;
        end
        bus_req = 1'b0;
        check("hold_acks", 32'(acks), 32'd1);
        @(negedge clk);

        // Reset during ACCESS of TERM write aborts it
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 4'h4; bus_wdata = 32'hFF;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ack", 32'(bus_ack), 32'd0);
        check("abort_term", ro_termcount, TERM_RST);
        check("abort_irq", 32'(irq), 32'd0);
        bus_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus_ack) acks++;
        end
        check("abort_noack", 32'(acks), 32'd0);
        check("abort_term2", ro_termcount, TERM_RST);

        // Reset mid-read with req held: served again after release
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 4'h4;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        acks = 0;
        rd = '0;
        repeat (4) begin
            @(negedge clk);
            if (bus_ack) begin
                acks++;
                rd = bus_rdata;
            end
        end
        bus_req = 1'b0;
        check("rearm_acks", 32'(acks), 32'd1);
        check("rearm_rd", rd, TERM_RST);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
